// File: rtl/alu_pkg.sv
// Shared definitions for the ALU self-test: opcodes, controller states and
// the packed layout of one test vector {a, b, op, exp_res, exp_c, exp_v, exp_z, exp_n}.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // Number of distinct vectors stored; indices past this wrap around.
  localparam int ROM_DEPTH = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } bist_state_e;

  // a, b, exp_res are WIDTH bits; op is 3 bits; four flag bits.
  function automatic int vec_w(input int width);
    return 3 * width + 7;
  endfunction

endpackage

// File: rtl/alu_bist_rom.sv
// Combinational test-vector ROM. Contents are written for a 4-bit ALU: one
// vector per opcode plus the signed-overflow corners for ADD and SUB.
module alu_bist_rom
  import alu_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NUM_VEC = 8
) (
  input  logic [((NUM_VEC > 1) ? $clog2(NUM_VEC) : 1)-1:0] idx,
  output logic [vec_w(WIDTH)-1:0]                          vec
);

  localparam int VW = vec_w(WIDTH);

  function automatic logic [VW-1:0] mk(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] op, input logic [3:0] r,
                                       input logic c, input logic v,
                                       input logic z, input logic n);
    return {WIDTH'(a), WIDTH'(b), op, WIDTH'(r), c, v, z, n};
  endfunction

  always_comb begin
    case (int'(idx) % ROM_DEPTH)
      0:       vec = mk(4'hF, 4'h1, OP_ADD, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0); // add wraps to zero
      1:       vec = mk(4'h5, 4'h5, OP_SUB, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0); // equal operands
      2:       vec = mk(4'hC, 4'hA, OP_AND, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1);
      3:       vec = mk(4'hA, 4'hC, OP_OR,  4'hE, 1'b0, 1'b0, 1'b0, 1'b1);
      4:       vec = mk(4'h6, 4'h3, OP_XOR, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);
      5:       vec = mk(4'h9, 4'h0, OP_SHL, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0);
      6:       vec = mk(4'h9, 4'h0, OP_SHR, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0);
      7:       vec = mk(4'h3, 4'h7, OP_SLT, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
      8:       vec = mk(4'h7, 4'h1, OP_ADD, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1); // +7+1 overflows
      default: vec = mk(4'h8, 4'h1, OP_SUB, 4'h7, 1'b0, 1'b1, 1'b0, 1'b0); // -8-1 overflows
    endcase
  end

endmodule

// File: rtl/alu_bist_ctrl.sv
// Built-in self-test controller for a combinational ALU: drives each ROM vector,
// waits SETTLE_CYC cycles, compares the ALU outputs and accumulates the verdict.
module alu_bist_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int NUM_VEC    = 8,
  parameter int SETTLE_CYC = 1,
  parameter int CHECK_ZN   = 0
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              start,
  input  logic                                              abort,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              pass,
  output logic [$clog2(NUM_VEC+1)-1:0]                      fail_count,
  output logic [((NUM_VEC > 1) ? $clog2(NUM_VEC) : 1)-1:0]  first_fail_idx,
  output logic [WIDTH-1:0]                                  first_fail_res,
  output logic [WIDTH-1:0]                                  alu_a,
  output logic [WIDTH-1:0]                                  alu_b,
  output logic [2:0]                                        alu_op,
  input  logic [WIDTH-1:0]                                  alu_res,
  input  logic                                              alu_carry,
  input  logic                                              alu_overflow,
  input  logic                                              alu_zero,
  input  logic                                              alu_neg,
  output bist_state_e                                       dbg_state_o
);

  localparam int IW  = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam int FCW = $clog2(NUM_VEC + 1);
  localparam int SCW = $clog2(SETTLE_CYC + 1);
  localparam int EW  = WIDTH + 4;

  // Handshake: start is a one-cycle request accepted only in IDLE/DONE; there is
  // no ready. done/pass/fail_* are the response and hold until the next start.
  bist_state_e           state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [SCW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]      a_q, a_d, b_q, b_d;
  logic [2:0]            op_q, op_d;
  logic [EW-1:0]         exp_q, exp_d;
  logic [FCW-1:0]        fc_q, fc_d;
  logic [IW-1:0]         ffi_q, ffi_d;
  logic [WIDTH-1:0]      ffr_q, ffr_d;
  logic                  pass_q, pass_d;

  logic [vec_w(WIDTH)-1:0] rom_vec;
  logic [WIDTH-1:0]      rom_a, rom_b;
  logic [2:0]            rom_op;
  logic [EW-1:0]         rom_exp;
  logic [EW-1:0]         got;
  logic                  mismatch;

  alu_bist_rom #(
    .WIDTH   (WIDTH),
    .NUM_VEC (NUM_VEC)
  ) u_rom (
    .idx (idx_q),
    .vec (rom_vec)
  );

  assign {rom_a, rom_b, rom_op, rom_exp} = rom_vec;
  assign got = {alu_res, alu_carry, alu_overflow, alu_zero, alu_neg};

  // Flags live in the low four bits: {c, v, z, n}.
  assign mismatch = (got[EW-1:2] !== exp_q[EW-1:2]) ||
                    ((CHECK_ZN != 0) && (got[1:0] !== exp_q[1:0]));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    exp_d   = exp_q;
    fc_d    = fc_q;
    ffi_d   = ffi_q;
    ffr_d   = ffr_q;
    pass_d  = pass_q;
    if (abort) begin
      state_d = ST_IDLE;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d = ST_DRIVE;
            idx_d   = '0;
            fc_d    = '0;
            ffi_d   = '0;
            ffr_d   = '0;
            pass_d  = 1'b0;
          end
        end
        ST_DRIVE: begin
          a_d     = rom_a;
          b_d     = rom_b;
          op_d    = rom_op;
          exp_d   = rom_exp;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_q == SCW'(SETTLE_CYC - 1)) state_d = ST_CHECK;
          else                               cnt_d   = cnt_q + SCW'(1);
        end
        ST_CHECK: begin
          if (mismatch) begin
            fc_d = fc_q + FCW'(1);
            if (fc_q == '0) begin
              ffi_d = idx_q;
              ffr_d = alu_res;
            end
          end
          if (idx_q == IW'(NUM_VEC - 1)) begin
            state_d = ST_DONE;
            pass_d  = (fc_d == '0);
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = ST_DRIVE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 3'b000;
      exp_q   <= '0;
      fc_q    <= '0;
      ffi_q   <= '0;
      ffr_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      exp_q   <= exp_d;
      fc_q    <= fc_d;
      ffi_q   <= ffi_d;
      ffr_q   <= ffr_d;
      pass_q  <= pass_d;
    end
  end

  assign busy           = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign done           = (state_q == ST_DONE);
  assign pass           = pass_q;
  assign fail_count     = fc_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_res = ffr_q;
  assign alu_a          = a_q;
  assign alu_b          = b_q;
  assign alu_op         = op_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Bench for alu_bist_ctrl: two instances (default and CHECK_ZN=1 / 10 vectors /
// 2 settle cycles) each driven against a behavioural ALU with injectable faults.
module tb_alu_bist_ctrl;
  import alu_pkg::*;

  localparam int NV0 = 8;
  localparam int S0  = 1;
  localparam int NV1 = 10;
  localparam int S1  = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start0, abort0, start1, abort1;
  logic [4:0] fmask0, fmask1;

  logic busy0, done0, pass0, c0, v0, z0, n0;
  logic [3:0] fc0, ffr0, a0, b0, res0;
  logic [2:0] ffi0, op0;
  bist_state_e st0;

  logic busy1, done1, pass1, c1, v1, z1, n1;
  logic [3:0] fc1, ffi1, ffr1, a1, b1, res1;
  logic [2:0] op1;
  bist_state_e st1;

  int n_checks = 0;
  int n_fail   = 0;

  // Operand table of the vectors the controller is expected to walk.
  int va [10] = '{15, 5, 12, 10, 6, 9, 9, 3, 7, 8};
  int vb [10] = '{ 1, 5, 10, 12, 3, 0, 0, 7, 1, 1};
  int vop[10] = '{ 0, 1,  2,  3, 4, 5, 6, 7, 0, 1};

  // Behavioural ALU; fm bits: 0 OR res=0, 1 ADD carry inverted, 2 XOR res lsb
  // flipped, 3 SUB zero forced 0, 4 SLT res flipped. Returns {res, c, v, z, n}.
  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] op, input logic [4:0] fm);
    int s;
    logic [3:0] r;
    logic c, v, z, n;
    c = 1'b0;
    v = 1'b0;
    s = 0;
    case (op)
      3'd0: begin
        s = int'(a) + int'(b);
        r = s[3:0];
        c = (s > 15) ^ fm[1];
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      3'd1: begin
        s = int'(a) - int'(b);
        r = s[3:0];
        c = (s < 0);
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      3'd2: r = a & b;
      3'd3: r = fm[0] ? 4'h0 : (a | b);
      3'd4: r = (a ^ b) ^ {3'b000, fm[2]};
      3'd5: r = {a[2:0], 1'b0};
      3'd6: r = {1'b0, a[3:1]};
      default: r = {3'b000, (a < b) ^ fm[4]};
    endcase
    z = (r == 4'h0) && !(op == 3'd1 && fm[3]);
    n = r[3];
    return {r, c, v, z, n};
  endfunction

  assign {res0, c0, v0, z0, n0} = alu_f(a0, b0, op0, fmask0);
  assign {res1, c1, v1, z1, n1} = alu_f(a1, b1, op1, fmask1);

  alu_bist_ctrl u0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_count(fc0),
    .first_fail_idx(ffi0), .first_fail_res(ffr0),
    .alu_a(a0), .alu_b(b0), .alu_op(op0), .alu_res(res0),
    .alu_carry(c0), .alu_overflow(v0), .alu_zero(z0), .alu_neg(n0),
    .dbg_state_o(st0)
  );

  alu_bist_ctrl #(.WIDTH(4), .NUM_VEC(NV1), .SETTLE_CYC(S1), .CHECK_ZN(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_count(fc1),
    .first_fail_idx(ffi1), .first_fail_res(ffr1),
    .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_res(res1),
    .alu_carry(c1), .alu_overflow(v1), .alu_zero(z1), .alu_neg(n1),
    .dbg_state_o(st1)
  );

  function automatic int get_busy(input int d); return d ? int'(busy1) : int'(busy0); endfunction
  function automatic int get_done(input int d); return d ? int'(done1) : int'(done0); endfunction
  function automatic int get_pass(input int d); return d ? int'(pass1) : int'(pass0); endfunction
  function automatic int get_fc  (input int d); return d ? int'(fc1)   : int'(fc0);   endfunction
  function automatic int get_ffi (input int d); return d ? int'(ffi1)  : int'(ffi0);  endfunction
  function automatic int get_ffr (input int d); return d ? int'(ffr1)  : int'(ffr0);  endfunction

  task automatic set_start(input int d, input logic val);
    if (d != 0) start1 = val;
    else        start0 = val;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: expected verdict of a full run with fault mask fm.
  task automatic predict(input int d, input logic [4:0] fm,
                         output int e_fc, output int e_ffi, output int e_ffr);
    logic [7:0] good, bad;
    bit mism;
    e_fc = 0; e_ffi = 0; e_ffr = 0;
    for (int i = 0; i < (d ? NV1 : NV0); i++) begin
      good = alu_f(4'(va[i]), 4'(vb[i]), 3'(vop[i]), 5'b0);
      bad  = alu_f(4'(va[i]), 4'(vb[i]), 3'(vop[i]), fm);
      mism = (good[7:2] != bad[7:2]) || (d != 0 && good[1:0] != bad[1:0]);
      if (mism) begin
        if (e_fc == 0) begin
          e_ffi = i;
          e_ffr = int'(bad[7:4]);
        end
        e_fc++;
      end
    end
  endtask

  // Full run; optionally pulses start once while busy (must be ignored).
  task automatic run(input int d, input logic [4:0] fm, input bit poke);
    int t, first_done, busy_cnt, poke_at, e_fc, e_ffi, e_ffr;
    t = (d ? NV1 * (S1 + 2) : NV0 * (S0 + 2)) + 1;
    if (d != 0) fmask1 = fm;
    else        fmask0 = fm;
    predict(d, fm, e_fc, e_ffi, e_ffr);
    poke_at = poke ? int'($urandom_range(2, t - 2)) : -1;
    @(negedge clk); set_start(d, 1'b1);
    @(negedge clk); set_start(d, 1'b0);
    first_done = -1;
    busy_cnt   = 0;
    for (int n = 1; n <= t + 4; n++) begin
      if (n > 1) @(negedge clk);
      if (get_busy(d) != 0) busy_cnt++;
      if (get_done(d) != 0 && first_done < 0) first_done = n;
      set_start(d, n == poke_at);
    end
    check($sformatf("done_cycle d%0d fm%0h", d, fm), first_done, t);
    check($sformatf("busy_cycles d%0d fm%0h", d, fm), busy_cnt, t - 1);
    check($sformatf("done_held d%0d", d), get_done(d), 1);
    check($sformatf("pass d%0d fm%0h", d, fm), get_pass(d), int'(e_fc == 0));
    check($sformatf("fail_count d%0d fm%0h", d, fm), get_fc(d), e_fc);
    check($sformatf("first_fail_idx d%0d fm%0h", d, fm), get_ffi(d), e_ffi);
    check($sformatf("first_fail_res d%0d fm%0h", d, fm), get_ffr(d), e_ffr);
  endtask

  initial begin
    int done_seen;
    rst = 1'b1;
    start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    fmask0 = '0; fmask1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_u0", {busy0, done0, pass0, fc0, ffi0, ffr0, a0, b0, op0}, 0);
    check("reset_u1", {busy1, done1, pass1, fc1, ffi1, ffr1, a1, b1, op1}, 0);

    // Test-plan faults, then randomized ones.
    run(0, 5'b00000, 1'b0);
    run(0, 5'b00001, 1'b0);
    run(0, 5'b00110, 1'b1);
    run(1, 5'b01000, 1'b0);
    run(0, 5'b01000, 1'b0);
    run(1, 5'b00000, 1'b1);
    for (int k = 0; k < 8; k++)
      run(int'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));

    // abort in DONE clears done and pass
    abort0 = 1'b1;
    @(negedge clk); abort0 = 1'b0;
    check("abort_done_clears", {done0, pass0, busy0}, 0);

    // reset during SETTLE of vector 3, with a failure already recorded
    fmask0 = 5'b00010;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_fail_count", fc0, 1);
    check("pre_rst_a", a0, 4'hA);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("mid_rst_outs", {busy0, done0, pass0, fc0, ffi0, ffr0, a0, b0, op0}, 0);
    run(0, 5'b00000, 1'b0);

    // abort during CHECK of vector 1 (cycle 6)
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (5) @(negedge clk);
    abort0 = 1'b1;
    @(negedge clk); abort0 = 1'b0;
    check("abort_check_busy", busy0, 0);
    done_seen = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done0 || busy0) done_seen++;
    end
    check("abort_check_stays_idle", done_seen, 0);

    // start and abort together from IDLE
    start1 = 1'b1; abort1 = 1'b1;
    @(negedge clk); start1 = 1'b0; abort1 = 1'b0;
    check("start_abort_same_cycle", {busy1, done1}, 0);
    @(negedge clk);
    check("start_abort_still_idle", {busy1, done1}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
